uart_block_bridge: RTL and testbench
====================================

# uart_block_bridge

- Sits between the UART FIFOs and the 128-bit datapath.
- Receive side: pops bytes from the Rx FIFO, assembles 16 of them into one 128-bit block and presents it on a valid/ready output.
- Transmit side: accepts a 128-bit block on a valid/ready input and pushes it into the Tx FIFO one byte at a time.
- An inter-byte timeout discards partial Rx blocks, so a dropped byte cannot misalign all later blocks.

## Interface
Parameters:
- DBITS, 8, bits per UART word; must be 8.
- BLOCK_BYTES, 16, bytes per block; block width is DBITS*BLOCK_BYTES = 128.
- TIMEOUT_CYCLES, 1_000_000, idle clocks allowed between bytes of a partial Rx block (10 ms at 100 MHz).
- TO_BITS, 20, width of the timeout counter.

Ports:
- clk_100MHz  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rx_empty  in  1  Rx FIFO empty.
- read_data  in  DBITS  Rx FIFO head word; valid whenever rx_empty=0.
- read_uart  out  1  one-cycle pop strobe to the Rx FIFO.
- tx_full  in  1  Tx FIFO full; tie to 0 if the FIFO does not export it.
- write_uart  out  1  one-cycle push strobe to the Tx FIFO.
- write_data  out  DBITS  byte being pushed.
- blk_out_data  out  128  assembled Rx block.
- blk_out_valid  out  1  blk_out_data is valid.
- blk_out_ready  in  1  consumer accepts the block.
- blk_in_data  in  128  block to transmit.
- blk_in_valid  in  1  blk_in_data is valid.
- blk_in_ready  out  1  bridge can accept a block.
- timeout_err  out  1  one-cycle pulse when a partial Rx block is discarded.

## Operation
Clock and reset:
- Single clock.
- Reset is synchronous and active-high.
- Reset values: read_uart=0, write_uart=0, write_data=0, blk_out_data=0, blk_out_valid=0, blk_in_ready=0, timeout_err=0.
- Both FSMs return to their first state and all counters clear.

Byte order is big-endian throughout:
- The first byte received lands in blk_out_data[127:120].
- blk_in_data[127:120] is the first byte transmitted.

Rx FSM, states RX_COLLECT and RX_HOLD:
- RX_COLLECT, rx_empty=0: drive read_uart=1 combinationally in that cycle.
  - Shift register ← {sr[119:0], read_data}; byte count bcnt (4 bits) increments.
  - Timeout counter clears.
- When the pop happens with bcnt=15, go to RX_HOLD and set blk_out_valid=1; bcnt wraps to 0.
- RX_HOLD: no pops, so backpressure is held in the Rx FIFO.
  - blk_out_data stays stable while blk_out_valid=1.
  - On blk_out_valid & blk_out_ready, clear valid and return to RX_COLLECT.
- Timeout, in RX_COLLECT with bcnt≠0 and no pop: the timer increments.
  - At TIMEOUT_CYCLES-1 the partial block is discarded: bcnt←0, timer←0, timeout_err=1 for one cycle.
  - The timer is frozen while bcnt=0 or in RX_HOLD.

Tx FSM, states TX_IDLE and TX_SEND:
- blk_in_ready = (state==TX_IDLE) & ~reset.
- On blk_in_valid & blk_in_ready: latch the block into the Tx shift register, set idx=0, go to TX_SEND.
- TX_SEND, tx_full=0: write_uart=1 and write_data = sr[127:120] in the same cycle; then sr ← sr<<8 and idx increments.
- After the push with idx=15, return to TX_IDLE.
- TX_SEND, tx_full=1: no push; state is held.
- write_data is 0 outside TX_SEND.

The Rx and Tx halves are fully independent and may operate simultaneously.

## Timing
Rx:
- blk_out_valid rises the cycle after the 16th pop.
- Minimum 16 cycles per block with a full FIFO, plus 1 cycle in RX_HOLD when ready is already high.

Tx:
- The first push happens the cycle after acceptance.
- The 16 pushes are contiguous when tx_full=0, giving 17 cycles per block.

Boundary conditions:
- A pop in the cycle the timer would expire wins: no timeout, timer clears.
- Reset mid-block: partial Rx bytes already popped are lost, and the in-progress Tx block is abandoned. The FIFOs share the same reset.
- rx_empty=1 in RX_COLLECT: read_uart must stay 0, so the bridge never pops an empty FIFO.
- tx_full=1: write_uart must stay 0, so the bridge never pushes a full FIFO.

## Structure
- Package uart_blk_pkg holds:
  - constants: BLOCK_BYTES, BLOCK_W=128, default TIMEOUT_CYCLES;
  - Rx state encoding: RX_COLLECT=0, RX_HOLD=1;
  - Tx state encoding: TX_IDLE=0, TX_SEND=1.
- One sub-module is natural: block_serializer (the Tx FSM, shift register and idx).
- The Rx assembler and timeout logic live in the top.

## Test plan
- Rx FIFO preloaded with 0x00..0x0F, blk_out_ready=1 → 16 consecutive read_uart pulses; blk_out_valid for 1 cycle with blk_out_data=0x000102…0E0F.
- Same preload with blk_out_ready=0 for 50 cycles and 16 more bytes queued → 16 bytes then no pops and data stable for 50 cycles; after ready, the second block is 0x10..0x1F.
- 5 bytes, then silence with TIMEOUT_CYCLES=100 → timeout_err pulses once at cycle 100 after the last pop; the next 16 bytes 0xA0..0xAF form a clean block.
- blk_in_data=0xDEADBEEF_00112233_44556677_8899AABB, tx_full=0 → write_data DE,AD,BE,EF,…,BB on 16 contiguous write_uart cycles; blk_in_ready low for 16 cycles then high.
- Same Tx block with tx_full=1 during bytes 4–9 → no push while full; the byte sequence is unchanged and complete.
- Reset asserted after 8 Rx pops and 8 Tx pushes → all outputs 0 the next cycle; a fresh 16-byte Rx stream and a new Tx block both complete correctly.

Source files
------------

// File: rtl/uart_blk_pkg.sv
// Shared constants and FSM state encodings for the UART block bridge.
package uart_blk_pkg;

  localparam int unsigned BLOCK_BYTES        = 16;
  localparam int unsigned BLOCK_W            = 128;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 1_000_000;

  typedef enum logic {
    RX_COLLECT = 1'b0,
    RX_HOLD    = 1'b1
  } rx_state_e;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_e;

endpackage

// File: rtl/uart_block_bridge_serializer.sv
// Tx half: latches one block and pushes it MSB byte first into the Tx FIFO.
module block_serializer #(
  parameter int unsigned DBITS       = 8,
  parameter int unsigned BLOCK_BYTES = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [DBITS*BLOCK_BYTES-1:0] blk_data_i,
  input  logic                         blk_valid_i,
  output logic                         blk_ready_o,
  input  logic                         tx_full_i,
  output logic                         push_o,
  output logic [DBITS-1:0]             push_data_o
);
  import uart_blk_pkg::*;

  localparam int unsigned BlkW = DBITS * BLOCK_BYTES;
  localparam int unsigned CntW = $clog2(BLOCK_BYTES);
  localparam logic [CntW-1:0] LastIdx = CntW'(BLOCK_BYTES - 1);

  tx_state_e         state_q;
  logic [BlkW-1:0]   sr_q;
  logic [CntW-1:0]   idx_q;
  logic              sending;

  assign sending     = ~rst_i & (state_q == TX_SEND);
  assign blk_ready_o = ~rst_i & (state_q == TX_IDLE);
  assign push_o      = sending & ~tx_full_i;
  assign push_data_o = sending ? sr_q[BlkW-1 -: DBITS] : '0;

  // Tx FSM: accept a block in idle, then shift one byte out per non-full cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= TX_IDLE;
      sr_q    <= '0;
      idx_q   <= '0;
    end else begin
      unique case (state_q)
        TX_IDLE: begin
          if (blk_valid_i) begin
            sr_q    <= blk_data_i;
            idx_q   <= '0;
            state_q <= TX_SEND;
          end
        end
        TX_SEND: begin
          if (!tx_full_i) begin
            sr_q <= sr_q << DBITS;
            if (idx_q == LastIdx) begin
              idx_q   <= '0;
              state_q <= TX_IDLE;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        default: state_q <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_block_bridge.sv
// Bridges byte-wide UART FIFOs to a 128-bit valid/ready block datapath.
// Rx assembly and the inter-byte timeout live here; Tx is in block_serializer.
module uart_block_bridge #(
  parameter int unsigned DBITS          = 8,
  parameter int unsigned BLOCK_BYTES    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned TO_BITS        = 20
) (
  input  logic                         clk_100MHz,
  input  logic                         reset,
  input  logic                         rx_empty,
  input  logic [DBITS-1:0]             read_data,
  output logic                         read_uart,
  input  logic                         tx_full,
  output logic                         write_uart,
  output logic [DBITS-1:0]             write_data,
  output logic [DBITS*BLOCK_BYTES-1:0] blk_out_data,
  output logic                         blk_out_valid,
  input  logic                         blk_out_ready,
  input  logic [DBITS*BLOCK_BYTES-1:0] blk_in_data,
  input  logic                         blk_in_valid,
  output logic                         blk_in_ready,
  output logic                         timeout_err
);
  import uart_blk_pkg::*;

  localparam int unsigned BlkW = DBITS * BLOCK_BYTES;
  localparam int unsigned CntW = $clog2(BLOCK_BYTES);
  localparam logic [CntW-1:0]    LastByte = CntW'(BLOCK_BYTES - 1);
  localparam logic [TO_BITS-1:0] ToLast   = TO_BITS'(TIMEOUT_CYCLES - 1);

  rx_state_e          rx_state_q;
  logic [BlkW-1:0]    rx_sr_q;
  logic [CntW-1:0]    bcnt_q;
  logic [TO_BITS-1:0] timer_q;
  logic               blk_out_valid_q;
  logic               timeout_err_q;
  logic               rx_pop;

  // Pop only while collecting and the FIFO has a word; never during reset.
  assign rx_pop        = ~reset & (rx_state_q == RX_COLLECT) & ~rx_empty;
  assign read_uart     = rx_pop;
  assign blk_out_data  = rx_sr_q;
  assign blk_out_valid = blk_out_valid_q;
  assign timeout_err   = timeout_err_q;

  // Rx FSM: shift bytes in big-endian order, hold the block until accepted,
  // and drop a stalled partial block so later blocks stay aligned.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      rx_state_q      <= RX_COLLECT;
      rx_sr_q         <= '0;
      bcnt_q          <= '0;
      timer_q         <= '0;
      blk_out_valid_q <= 1'b0;
      timeout_err_q   <= 1'b0;
    end else begin
      timeout_err_q <= 1'b0;
      unique case (rx_state_q)
        RX_COLLECT: begin
          if (rx_pop) begin
            rx_sr_q <= {rx_sr_q[BlkW-DBITS-1:0], read_data};
            timer_q <= '0;
            if (bcnt_q == LastByte) begin
              bcnt_q          <= '0;
              rx_state_q      <= RX_HOLD;
              blk_out_valid_q <= 1'b1;
            end else begin
              bcnt_q <= bcnt_q + 1'b1;
            end
          end else if (bcnt_q != '0) begin
            // A pop in the expiry cycle takes the branch above, so it wins.
            if (timer_q == ToLast) begin
              bcnt_q        <= '0;
              timer_q       <= '0;
              timeout_err_q <= 1'b1;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end
        end
        RX_HOLD: begin
          if (blk_out_ready) begin
            blk_out_valid_q <= 1'b0;
            rx_state_q      <= RX_COLLECT;
          end
        end
        default: rx_state_q <= RX_COLLECT;
      endcase
    end
  end

  block_serializer #(
    .DBITS      (DBITS),
    .BLOCK_BYTES(BLOCK_BYTES)
  ) u_serializer (
    .clk_i      (clk_100MHz),
    .rst_i      (reset),
    .blk_data_i (blk_in_data),
    .blk_valid_i(blk_in_valid),
    .blk_ready_o(blk_in_ready),
    .tx_full_i  (tx_full),
    .push_o     (write_uart),
    .push_data_o(write_data)
  );

endmodule

// File: tb/tb_uart_block_bridge.sv
// Directed testbench for uart_block_bridge with simple Rx/Tx FIFO models.
module tb_uart_block_bridge;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         rx_empty;
  logic [7:0]   read_data;
  logic         read_uart;
  logic         tx_full = 1'b0;
  logic         write_uart;
  logic [7:0]   write_data;
  logic [127:0] blk_out_data;
  logic         blk_out_valid;
  logic         blk_out_ready = 1'b0;
  logic [127:0] blk_in_data = '0;
  logic         blk_in_valid = 1'b0;
  logic         blk_in_ready;
  logic         timeout_err;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  uart_block_bridge #(
    .DBITS         (8),
    .BLOCK_BYTES   (16),
    .TIMEOUT_CYCLES(100),
    .TO_BITS       (20)
  ) dut (
    .clk_100MHz   (clk),
    .reset        (reset),
    .rx_empty     (rx_empty),
    .read_data    (read_data),
    .read_uart    (read_uart),
    .tx_full      (tx_full),
    .write_uart   (write_uart),
    .write_data   (write_data),
    .blk_out_data (blk_out_data),
    .blk_out_valid(blk_out_valid),
    .blk_out_ready(blk_out_ready),
    .blk_in_data  (blk_in_data),
    .blk_in_valid (blk_in_valid),
    .blk_in_ready (blk_in_ready),
    .timeout_err  (timeout_err)
  );

  // Rx FIFO model: bench writes rx_mem/rx_wr, the clocked process owns rx_rd.
  logic [7:0] rx_mem [256];
  logic [7:0] rx_wr = 8'd0;
  logic [7:0] rx_rd = 8'd0;
  int         pop_viol = 0;
  assign rx_empty  = (rx_rd == rx_wr);
  assign read_data = rx_mem[rx_rd];

  always @(posedge clk) begin
    if (reset) rx_rd <= rx_wr;
    else if (read_uart) begin
      if (rx_rd == rx_wr) pop_viol <= pop_viol + 1;
      else rx_rd <= rx_rd + 8'd1;
    end
  end

  // Tx FIFO model: logs every push and flags pushes into a full FIFO.
  logic [7:0] tx_log [256];
  logic [7:0] tx_n = 8'd0;
  int         push_viol = 0;
  always @(posedge clk) begin
    if (write_uart && tx_full) push_viol <= push_viol + 1;
    if (!reset && write_uart) begin
      tx_log[tx_n] <= write_data;
      tx_n         <= tx_n + 8'd1;
    end
  end

  int err_total = 0;
  always @(negedge clk) if (timeout_err) err_total <= err_total + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got hang want completion");
    $fatal(1);
  end

  // Move to just after the next rising edge; all stimulus is driven there.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_rx(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      rx_mem[rx_wr] = first + 8'(i);
      rx_wr = rx_wr + 8'd1;
    end
  endtask

  task automatic wait_block(output logic [127:0] d, output int pops, output bit found,
                            input int budget);
    found = 1'b0;
    pops  = 0;
    d     = '0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (read_uart) pops++;
      if (blk_out_valid) begin
        found = 1'b1;
        d     = blk_out_data;
      end
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    @(negedge clk);
    checks++; if (read_uart !== 1'b0) $display("FAIL rst_read_uart got %b want 0", read_uart); else passed++;
    checks++; if (write_uart !== 1'b0) $display("FAIL rst_write_uart got %b want 0", write_uart); else passed++;
    checks++; if (write_data !== 8'h00) $display("FAIL rst_write_data got %h want 00", write_data); else passed++;
    checks++; if (blk_out_data !== 128'h0) $display("FAIL rst_blk_out_data got %h want 0", blk_out_data); else passed++;
    checks++; if (blk_out_valid !== 1'b0) $display("FAIL rst_blk_out_valid got %b want 0", blk_out_valid); else passed++;
    checks++; if (blk_in_ready !== 1'b0) $display("FAIL rst_blk_in_ready got %b want 0", blk_in_ready); else passed++;
    checks++; if (timeout_err !== 1'b0) $display("FAIL rst_timeout_err got %b want 0", timeout_err); else passed++;
    step();
    reset = 1'b0;
    @(negedge clk);
    checks++; if (blk_in_ready !== 1'b1) $display("FAIL post_rst_ready got %b want 1", blk_in_ready); else passed++;
    checks++; if (read_uart !== 1'b0) $display("FAIL empty_no_pop got %b want 0", read_uart); else passed++;
    step();
  endtask

  task automatic test_rx_basic();
    int first_pop = -1, last_pop = -1, pops = 0, vcnt = 0, vcyc = -1;
    logic [127:0] d = '0;
    blk_out_ready = 1'b1;
    load_rx(8'h00, 16);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (read_uart) begin
        if (first_pop < 0) first_pop = c;
        last_pop = c;
        pops++;
      end
      if (blk_out_valid) begin
        vcnt++;
        vcyc = c;
        d    = blk_out_data;
      end
      step();
    end
    checks++; if (pops != 16) $display("FAIL rx_pops got %0d want 16", pops); else passed++;
    checks++; if (first_pop != 0) $display("FAIL rx_first_pop got %0d want 0", first_pop); else passed++;
    checks++; if (last_pop != 15) $display("FAIL rx_contiguous got last %0d want 15", last_pop); else passed++;
    checks++; if (vcnt != 1) $display("FAIL rx_valid_cycles got %0d want 1", vcnt); else passed++;
    checks++; if (vcyc != 16) $display("FAIL rx_valid_cycle got %0d want 16", vcyc); else passed++;
    checks++; if (d !== 128'h000102030405060708090A0B0C0D0E0F) $display("FAIL rx_block got %h want 000102030405060708090a0b0c0d0e0f", d); else passed++;
  endtask

  task automatic test_rx_backpressure();
    logic [127:0] d, d2;
    int pops, pops2, stray = 0, unstable = 0;
    bit found, found2;
    blk_out_ready = 1'b0;
    load_rx(8'h00, 16);
    load_rx(8'h10, 16);
    wait_block(d, pops, found, 40);
    checks++; if (!found) $display("FAIL bp_first_found got 0 want 1"); else passed++;
    checks++; if (d !== 128'h000102030405060708090A0B0C0D0E0F) $display("FAIL bp_first_block got %h want 000102030405060708090a0b0c0d0e0f", d); else passed++;
    checks++; if (pops != 16) $display("FAIL bp_first_pops got %0d want 16", pops); else passed++;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (read_uart) stray++;
      if (!blk_out_valid || blk_out_data !== d) unstable++;
      step();
    end
    checks++; if (stray != 0) $display("FAIL bp_no_pops got %0d want 0", stray); else passed++;
    checks++; if (unstable != 0) $display("FAIL bp_stable got %0d bad cycles want 0", unstable); else passed++;
    blk_out_ready = 1'b1;
    @(negedge clk);
    checks++; if (blk_out_valid !== 1'b1) $display("FAIL bp_valid_held got %b want 1", blk_out_valid); else passed++;
    step();
    wait_block(d2, pops2, found2, 40);
    checks++; if (!found2) $display("FAIL bp_second_found got 0 want 1"); else passed++;
    checks++; if (d2 !== 128'h101112131415161718191A1B1C1D1E1F) $display("FAIL bp_second_block got %h want 101112131415161718191a1b1c1d1e1f", d2); else passed++;
    checks++; if (pops2 != 16) $display("FAIL bp_second_pops got %0d want 16", pops2); else passed++;
  endtask

  task automatic test_timeout();
    int last_pop = -1, first_err = -1, vcnt = 0, e0, pops;
    logic [127:0] d;
    bit found;
    blk_out_ready = 1'b1;
    e0 = err_total;
    load_rx(8'h50, 5);
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      if (read_uart) last_pop = c;
      if (timeout_err && first_err < 0) first_err = c;
      if (blk_out_valid) vcnt++;
      step();
    end
    checks++; if (last_pop != 4) $display("FAIL to_last_pop got %0d want 4", last_pop); else passed++;
    // Timer reaches 99 in the 100th idle cycle; the registered pulse shows one cycle later.
    checks++; if (first_err - last_pop != 101) $display("FAIL to_err_delay got %0d want 101", first_err - last_pop); else passed++;
    checks++; if (err_total - e0 != 1) $display("FAIL to_err_count got %0d want 1", err_total - e0); else passed++;
    checks++; if (vcnt != 0) $display("FAIL to_no_block got %0d want 0", vcnt); else passed++;
    load_rx(8'hA0, 16);
    wait_block(d, pops, found, 40);
    checks++; if (!found) $display("FAIL to_clean_found got 0 want 1"); else passed++;
    checks++; if (d !== 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF) $display("FAIL to_clean_block got %h want a0a1a2a3a4a5a6a7a8a9aaabacadaeaf", d); else passed++;
    checks++; if (pops != 16) $display("FAIL to_clean_pops got %0d want 16", pops); else passed++;
  endtask

  task automatic test_timeout_race();
    int e0, pops;
    logic [127:0] d;
    bit found;
    e0 = err_total;
    load_rx(8'hC0, 1);
    for (int c = 0; c < 100; c++) step();
    // Timer now sits at its last value; this pop must beat the expiry.
    load_rx(8'hC1, 1);
    @(negedge clk);
    checks++; if (read_uart !== 1'b1) $display("FAIL race_pop got %b want 1", read_uart); else passed++;
    step();
    load_rx(8'hC2, 14);
    wait_block(d, pops, found, 40);
    checks++; if (!found) $display("FAIL race_found got 0 want 1"); else passed++;
    checks++; if (d !== 128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF) $display("FAIL race_block got %h want c0c1c2c3c4c5c6c7c8c9cacbcccdcecf", d); else passed++;
    checks++; if (err_total != e0) $display("FAIL race_no_err got %0d want %0d", err_total, e0); else passed++;
  endtask

  task automatic test_tx_basic();
    logic [127:0] e = 128'hDEADBEEF_00112233_44556677_8899AABB;
    logic [7:0] base = tx_n;
    int rdy_bad = 0, log_bad = 0;
    blk_in_data  = e;
    blk_in_valid = 1'b1;
    @(negedge clk);
    checks++; if (blk_in_ready !== 1'b1) $display("FAIL tx_ready_idle got %b want 1", blk_in_ready); else passed++;
    step();
    blk_in_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      checks++;
      if ({write_uart, write_data} !== {1'b1, e[127-8*k -: 8]})
        $display("FAIL tx_byte%0d got wr=%b %h want wr=1 %h", k, write_uart, write_data, e[127-8*k -: 8]);
      else passed++;
      if (blk_in_ready !== 1'b0) rdy_bad++;
      step();
    end
    @(negedge clk);
    checks++; if (rdy_bad != 0) $display("FAIL tx_ready_low got %0d bad cycles want 0", rdy_bad); else passed++;
    checks++; if (blk_in_ready !== 1'b1) $display("FAIL tx_ready_back got %b want 1", blk_in_ready); else passed++;
    checks++; if ({write_uart, write_data} !== 9'h000) $display("FAIL tx_idle_out got wr=%b %h want wr=0 00", write_uart, write_data); else passed++;
    step();
    for (int i = 0; i < 16; i++) if (tx_log[base + 8'(i)] !== e[127-8*i -: 8]) log_bad++;
    checks++; if (tx_n - base != 8'd16) $display("FAIL tx_push_count got %0d want 16", tx_n - base); else passed++;
    checks++; if (log_bad != 0) $display("FAIL tx_log got %0d bad bytes want 0", log_bad); else passed++;
  endtask

  task automatic test_tx_full();
    logic [127:0] e = 128'hDEADBEEF_00112233_44556677_8899AABB;
    logic [7:0] base = tx_n;
    int bad = 0, log_bad = 0;
    blk_in_data  = e;
    blk_in_valid = 1'b1;
    step();
    blk_in_valid = 1'b0;
    for (int k = 0; k < 22; k++) begin
      tx_full = (k >= 4 && k <= 9);
      @(negedge clk);
      if (k >= 4 && k <= 9) begin
        if (write_uart !== 1'b0) bad++;
      end else begin
        if ({write_uart, write_data} !== {1'b1, e[127-8*(k < 4 ? k : k-6) -: 8]}) bad++;
      end
      step();
    end
    tx_full = 1'b0;
    @(negedge clk);
    checks++; if (bad != 0) $display("FAIL txf_sequence got %0d bad cycles want 0", bad); else passed++;
    checks++; if (blk_in_ready !== 1'b1) $display("FAIL txf_ready_back got %b want 1", blk_in_ready); else passed++;
    step();
    for (int i = 0; i < 16; i++) if (tx_log[base + 8'(i)] !== e[127-8*i -: 8]) log_bad++;
    checks++; if (tx_n - base != 8'd16) $display("FAIL txf_push_count got %0d want 16", tx_n - base); else passed++;
    checks++; if (log_bad != 0) $display("FAIL txf_log got %0d bad bytes want 0", log_bad); else passed++;
  endtask

  task automatic test_reset_mid();
    logic [127:0] e = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
    logic [127:0] d;
    logic [7:0] base;
    int pops = 0, pushes = 0, pops2, log_bad = 0;
    bit found;
    blk_out_ready = 1'b1;
    blk_in_data   = 128'h11111111_22222222_33333333_44444444;
    blk_in_valid  = 1'b1;
    step();
    blk_in_valid = 1'b0;
    load_rx(8'h60, 16);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (read_uart) pops++;
      if (write_uart) pushes++;
      step();
    end
    reset = 1'b1;
    step();
    @(negedge clk);
    checks++; if (pops != 8) $display("FAIL mid_pops got %0d want 8", pops); else passed++;
    checks++; if (pushes != 8) $display("FAIL mid_pushes got %0d want 8", pushes); else passed++;
    checks++; if ({read_uart, write_uart, blk_out_valid, blk_in_ready, timeout_err} !== 5'b0)
      $display("FAIL mid_rst_flags got %b want 00000", {read_uart, write_uart, blk_out_valid, blk_in_ready, timeout_err}); else passed++;
    checks++; if (write_data !== 8'h00) $display("FAIL mid_rst_wdata got %h want 00", write_data); else passed++;
    checks++; if (blk_out_data !== 128'h0) $display("FAIL mid_rst_bdata got %h want 0", blk_out_data); else passed++;
    step();
    reset = 1'b0;
    base = tx_n;
    blk_in_data  = e;
    blk_in_valid = 1'b1;
    step();
    blk_in_valid = 1'b0;
    load_rx(8'h70, 16);
    wait_block(d, pops2, found, 40);
    for (int c = 0; c < 4; c++) step();
    for (int i = 0; i < 16; i++) if (tx_log[base + 8'(i)] !== e[127-8*i -: 8]) log_bad++;
    checks++; if (!found || d !== 128'h707172737475767778797A7B7C7D7E7F)
      $display("FAIL mid_rx_block got found=%b %h want 707172737475767778797a7b7c7d7e7f", found, d); else passed++;
    checks++; if (pops2 != 16) $display("FAIL mid_rx_pops got %0d want 16", pops2); else passed++;
    checks++; if (tx_n - base != 8'd16) $display("FAIL mid_tx_count got %0d want 16", tx_n - base); else passed++;
    checks++; if (log_bad != 0) $display("FAIL mid_tx_log got %0d bad bytes want 0", log_bad); else passed++;
  endtask

  initial begin
    test_reset();
    test_rx_basic();
    test_rx_backpressure();
    test_timeout();
    test_timeout_race();
    test_tx_basic();
    test_tx_full();
    test_reset_mid();
    checks++; if (pop_viol != 0) $display("FAIL pop_empty got %0d want 0", pop_viol); else passed++;
    checks++; if (push_viol != 0) $display("FAIL push_full got %0d want 0", push_viol); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
